// File: rtl/conv_window_sched_if.sv
// conv_window_sched_if
//   Bundles the signals between the pixel loader / downstream consumer and
//   the 3x3 convolution window scheduler.
//
//   Handshake rules (all sampled on the rising edge of clk):
//     pixel : a pixel transfers on every cycle where pix_valid & pix_ready.
//             The loader may raise or drop pix_valid freely. pix_ready is
//             only high while the scheduler is filling or streaming.
//     window: win_valid marks a valid 3x3 window with out_row/out_col.
//             When BACKPRESSURE_EN is defined, the window transfers on
//             win_valid & win_ready, and win_valid/out_row/out_col stay
//             stable until that happens. Without the macro, win_valid is a
//             single-cycle pulse and the consumer is always ready.
//
//   Optional feature macro: BACKPRESSURE_EN (adds win_ready).
//
//   Modports:
//     master : loader / consumer side (drives start, cfg_*, pix_valid, win_ready)
//     slave  : scheduler side (drives pix_ready, FIFO strobes, window, status)
//   state_dbg exposes the scheduler FSM state for checkers.

interface conv_window_sched_if #(
  parameter int DIM_W    = 5,
  parameter int STRIDE_W = 3
);
  logic                start;
  logic [DIM_W-1:0]    cfg_row_len;
  logic [DIM_W-1:0]    cfg_col_len;
  logic [STRIDE_W-1:0] cfg_stride;
  logic                pix_valid;
  logic                pix_ready;
  logic                ff_rst;
  logic                ff_wen;
  logic                ff_ren;
  logic                win_valid;
  logic [DIM_W-1:0]    out_row;
  logic [DIM_W-1:0]    out_col;
  logic                busy;
  logic                done;
  logic                cfg_err;
  logic [2:0]          state_dbg;
`ifdef BACKPRESSURE_EN
  logic                win_ready;

  modport master (
    output start, cfg_row_len, cfg_col_len, cfg_stride, pix_valid, win_ready,
    input  pix_ready, ff_rst, ff_wen, ff_ren, win_valid, out_row, out_col,
           busy, done, cfg_err, state_dbg
  );

  modport slave (
    input  start, cfg_row_len, cfg_col_len, cfg_stride, pix_valid, win_ready,
    output pix_ready, ff_rst, ff_wen, ff_ren, win_valid, out_row, out_col,
           busy, done, cfg_err, state_dbg
  );
`else
  modport master (
    output start, cfg_row_len, cfg_col_len, cfg_stride, pix_valid,
    input  pix_ready, ff_rst, ff_wen, ff_ren, win_valid, out_row, out_col,
           busy, done, cfg_err, state_dbg
  );

  modport slave (
    input  start, cfg_row_len, cfg_col_len, cfg_stride, pix_valid,
    output pix_ready, ff_rst, ff_wen, ff_ren, win_valid, out_row, out_col,
           busy, done, cfg_err, state_dbg
  );
`endif
endinterface

// File: rtl/conv_window_sched.sv
// conv_window_sched
//   Sequencing controller for the 3x3 convolution line-buffer FIFO. Accepts a
//   raster pixel stream, drives the FIFO clear/write/read strobes, tracks the
//   input row/column position and flags every stride-aligned 3x3 window with
//   its output-map coordinates. One frame is processed per start pulse.
//
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-high reset
//     bus : conv_window_sched_if.slave
//           start, cfg_row_len, cfg_col_len, cfg_stride, pix_valid -> in
//           pix_ready, ff_rst, ff_wen, ff_ren, win_valid, out_row,
//           out_col, busy, done, cfg_err, state_dbg               -> out
//           win_ready -> in (only with BACKPRESSURE_EN)
//
//   Optional feature macro: BACKPRESSURE_EN. When defined, a window that is
//   not taken (win_ready low) is held and the pixel stream is stalled until
//   it is taken; done is reported together with the final window transfer.

module conv_window_sched #(
  parameter int DIM_W    = 5,
  parameter int STRIDE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  conv_window_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FILL   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;

  // Latched frame configuration
  logic [DIM_W-1:0] row_len;
  logic [DIM_W-1:0] col_len;
  logic             stride2;

  // Input position and line-fill progress
  logic [DIM_W-1:0] in_row;
  logic [DIM_W-1:0] in_col;
  logic [DIM_W:0]   fill_cnt;

  // Stride phase of the current row/column; 0 means stride-aligned.
  logic             phase_r;
  logic             phase_c;

  // Output-map coordinates the next aligned window will carry.
  logic [DIM_W-1:0] orow_cnt;
  logic [DIM_W-1:0] ocol_cnt;

  // Registered outputs
  logic             win_valid_r;
  logic [DIM_W-1:0] out_row_r;
  logic [DIM_W-1:0] out_col_r;
  logic             done_r;
  logic             cfg_err_r;
  logic             ff_rst_r;

  logic             cfg_legal;
  logic             hold;
  logic             pix_ready_c;
  logic             accept;
  logic             col_wrap;
  logic             last_pix;
  logic             col_hit;
  logic             row_hit;
  logic             win_hit;
  logic [DIM_W-1:0] col_nxt;
  logic [DIM_W-1:0] row_nxt;
  logic [DIM_W:0]   fill_nxt;

  assign cfg_legal = (bus.cfg_row_len >= DIM_W'(3)) &&
                     (bus.cfg_col_len >= DIM_W'(3)) &&
                     ((bus.cfg_stride == STRIDE_W'(1)) ||
                      (bus.cfg_stride == STRIDE_W'(2)));

  // A pending, untaken window freezes the pixel side.
`ifdef BACKPRESSURE_EN
  assign hold = win_valid_r & ~bus.win_ready;
`else
  assign hold = 1'b0;
`endif

  assign pix_ready_c = ((state == S_FILL) || (state == S_STREAM)) && !hold;
  assign accept      = bus.pix_valid & pix_ready_c;

  assign col_nxt  = in_col + DIM_W'(1);
  assign row_nxt  = in_row + DIM_W'(1);
  assign fill_nxt = fill_cnt + (DIM_W+1)'(1);
  assign col_wrap = (in_col == row_len - DIM_W'(1));
  assign last_pix = col_wrap && (in_row == col_len - DIM_W'(1));

  // The bottom-right pixel of a window sits at column/row >= 2 on an
  // aligned phase; decided on the position before this accept's update.
  assign col_hit = (in_col >= DIM_W'(2)) && !phase_c;
  assign row_hit = (in_row >= DIM_W'(2)) && !phase_r;
  assign win_hit = accept && col_hit && row_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      row_len     <= '0;
      col_len     <= '0;
      stride2     <= 1'b0;
      in_row      <= '0;
      in_col      <= '0;
      fill_cnt    <= '0;
      phase_r     <= 1'b0;
      phase_c     <= 1'b0;
      orow_cnt    <= '0;
      ocol_cnt    <= '0;
      win_valid_r <= 1'b0;
      out_row_r   <= '0;
      out_col_r   <= '0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
      ff_rst_r    <= 1'b0;
    end else begin
      cfg_err_r <= 1'b0;
      ff_rst_r  <= 1'b0;

      // Window register: load on a hit, otherwise hold while stalled
      // downstream, otherwise drop.
      if (win_hit) begin
        win_valid_r <= 1'b1;
        out_row_r   <= orow_cnt;
        out_col_r   <= ocol_cnt;
      end else if (!hold) begin
        win_valid_r <= 1'b0;
      end

      // Position, phase and output-coordinate counters move only on accept.
      if (accept) begin
        if (col_wrap) begin
          in_col   <= '0;
          phase_c  <= 1'b0;
          ocol_cnt <= '0;
          in_row   <= row_nxt;
          phase_r  <= (row_nxt == DIM_W'(2)) ? 1'b0 : (phase_r ^ stride2);
          if (row_hit) begin
            orow_cnt <= orow_cnt + DIM_W'(1);
          end
        end else begin
          in_col  <= col_nxt;
          phase_c <= (col_nxt == DIM_W'(2)) ? 1'b0 : (phase_c ^ stride2);
          if (col_hit) begin
            ocol_cnt <= ocol_cnt + DIM_W'(1);
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (cfg_legal) begin
              row_len  <= bus.cfg_row_len;
              col_len  <= bus.cfg_col_len;
              stride2  <= (bus.cfg_stride == STRIDE_W'(2));
              ff_rst_r <= 1'b1;
              state    <= S_CLEAR;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          in_row   <= '0;
          in_col   <= '0;
          fill_cnt <= '0;
          phase_r  <= 1'b0;
          phase_c  <= 1'b0;
          orow_cnt <= '0;
          ocol_cnt <= '0;
          state    <= S_FILL;
        end

        // Two full lines must be in the FIFO before reads start.
        S_FILL: begin
          if (accept) begin
            fill_cnt <= fill_nxt;
            if (fill_nxt == {row_len, 1'b0}) begin
              state <= S_STREAM;
            end
          end
        end

        S_STREAM: begin
          if (accept && last_pix) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end

        // done_r is masked while the final window waits downstream, so the
        // visible pulse lands on the cycle that window is taken.
        S_DONE: begin
          if (!hold) begin
            done_r <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pix_ready = pix_ready_c;
  assign bus.ff_wen    = accept;
  assign bus.ff_ren    = accept && (state == S_STREAM);
  assign bus.ff_rst    = ff_rst_r;
  assign bus.win_valid = win_valid_r;
  assign bus.out_row   = out_row_r;
  assign bus.out_col   = out_col_r;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_r & ~hold;
  assign bus.cfg_err   = cfg_err_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_conv_window_sched.sv
module tb_conv_window_sched;
  localparam int DIM_W    = 5;
  localparam int STRIDE_W = 3;
  localparam int EXP_W    = 16 + 2*DIM_W;

  logic clk;
  logic rst;

  conv_window_sched_if #(.DIM_W(DIM_W), .STRIDE_W(STRIDE_W)) bus ();

  conv_window_sched #(.DIM_W(DIM_W), .STRIDE_W(STRIDE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entry: {pixel index of bottom-right pixel, out_row, out_col}
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;

  int   acc_cnt;
  int   frame_total;
  int   n_wen, n_ren, n_rst, n_done, n_cfgerr;
  logic exp_last_win;
  logic frame_done;
  logic was_hold;
  logic [2*DIM_W-1:0] held_coord;
  logic win_ok;

`ifdef BACKPRESSURE_EN
  assign win_ok = bus.win_ready;

  // Stall every window for three cycles, then take it.
  initial begin
    int stall;
    stall = 0;
    bus.win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus.win_valid && stall < 3) begin
        bus.win_ready = 1'b0;
        stall++;
      end else begin
        bus.win_ready = 1'b1;
        stall = 0;
      end
    end
  end
`else
  assign win_ok = 1'b1;
`endif

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, actual, expected);
  endtask

  // ---------------- reference model ----------------
  // Windows follow directly from geometry: bottom-right pixel (r,c) with
  // r,c >= 2 and (r-2),(c-2) multiples of the stride.
  task automatic model_frame(input int rl, input int cl, input int s);
    logic [15:0]      idx16;
    logic [DIM_W-1:0] orow;
    logic [DIM_W-1:0] ocol;
    exp_q.delete();
    for (int r = 0; r < cl; r++) begin
      for (int c = 0; c < rl; c++) begin
        if (r >= 2 && c >= 2 && ((r-2) % s) == 0 && ((c-2) % s) == 0) begin
          idx16 = 16'(r*rl + c + 1);
          orow  = DIM_W'((r-2) / s);
          ocol  = DIM_W'((c-2) / s);
          exp_q.push_back({idx16, orow, ocol});
        end
      end
    end
    frame_total  = rl * cl;
    exp_last_win = (((cl-3) % s) == 0) && (((rl-3) % s) == 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.win_valid && win_ok) begin
        if (exp_q.size() == 0) begin
          check("win_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("win_coord", int'({bus.out_row, bus.out_col}), int'(mon_e[2*DIM_W-1:0]));
          check("win_latency_idx", acc_cnt, int'(mon_e[EXP_W-1:2*DIM_W]));
        end
      end
      if (bus.win_valid && !win_ok) begin
        check("hold_pix_ready", int'(bus.pix_ready), 0);
        if (was_hold) check("hold_coord", int'({bus.out_row, bus.out_col}), int'(held_coord));
      end
      was_hold   = bus.win_valid && !win_ok;
      held_coord = {bus.out_row, bus.out_col};
      if (bus.done) begin
        check("done_pixels", acc_cnt, frame_total);
        check("done_with_win", int'(bus.win_valid && win_ok), int'(exp_last_win));
        n_done++;
        frame_done = 1'b1;
      end
      if (bus.cfg_err) n_cfgerr++;
      if (bus.ff_wen)  n_wen++;
      if (bus.ff_ren)  n_ren++;
      if (bus.ff_rst)  n_rst++;
      if (bus.pix_valid && bus.pix_ready) acc_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    acc_cnt    = 0;
    n_wen      = 0;
    n_ren      = 0;
    n_rst      = 0;
    n_done     = 0;
    n_cfgerr   = 0;
    frame_done = 1'b0;
    was_hold   = 1'b0;
  endtask

  task automatic start_frame(input int rl, input int cl, input int s);
    clear_counts();
    model_frame(rl, cl, s);
    @(posedge clk); #1;
    bus.cfg_row_len = DIM_W'(rl);
    bus.cfg_col_len = DIM_W'(cl);
    bus.cfg_stride  = STRIDE_W'(s);
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start       = 1'b0;
  endtask

  // Random pix_valid at the given duty; stray start pulses and config
  // changes mid-frame must have no effect. stop_acc > 0 stops early.
  task automatic drive(input int duty, input int stop_acc);
    int cyc;
    cyc = 0;
    while (!frame_done && cyc < 4000 && !(stop_acc > 0 && acc_cnt >= stop_acc)) begin
      @(posedge clk); #1;
      bus.pix_valid   = ($urandom_range(1, 100) <= duty);
      bus.start       = ($urandom_range(0, 19) == 0);
      bus.cfg_row_len = DIM_W'($urandom_range(0, 31));
      bus.cfg_col_len = DIM_W'($urandom_range(0, 31));
      bus.cfg_stride  = STRIDE_W'($urandom_range(0, 7));
      cyc++;
    end
    bus.pix_valid = 1'b0;
    bus.start     = 1'b0;
    if (stop_acc == 0 && !frame_done) check("frame_timeout", cyc, -1);
  endtask

  task automatic run_full(input int rl, input int cl, input int s, input int duty);
    start_frame(rl, cl, s);
    drive(duty, 0);
    check("frame_done", int'(frame_done), 1);
    check("win_remaining", exp_q.size(), 0);
    check("ff_wen_count", n_wen, rl*cl);
    check("ff_ren_count", n_ren, rl*cl - 2*rl);
    check("ff_rst_count", n_rst, 1);
    check("done_count", n_done, 1);
    @(posedge clk); #1;
    check("busy_after_frame", int'(bus.busy), 0);
  endtask

  task automatic cfg_err_case(input int rl, input int cl, input int s);
    clear_counts();
    @(posedge clk); #1;
    bus.cfg_row_len = DIM_W'(rl);
    bus.cfg_col_len = DIM_W'(cl);
    bus.cfg_stride  = STRIDE_W'(s);
    bus.pix_valid   = 1'b1;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("cfg_err_pulse", int'(bus.cfg_err), 1);
    check("cfg_err_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    check("cfg_err_clear", int'(bus.cfg_err), 0);
    repeat (3) @(posedge clk);
    #1;
    check("cfg_err_busy_later", int'(bus.busy), 0);
    check("cfg_err_count", n_cfgerr, 1);
    check("cfg_err_no_rst", n_rst, 0);
    check("cfg_err_no_wen", n_wen, 0);
    bus.pix_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      int'(bus.busy), 0);
    check({tag, "_pix_ready"}, int'(bus.pix_ready), 0);
    check({tag, "_ff_strobes"}, int'({bus.ff_rst, bus.ff_wen, bus.ff_ren}), 0);
    check({tag, "_win"}, int'({bus.win_valid, bus.out_row, bus.out_col}), 0);
    check({tag, "_done_err"}, int'({bus.done, bus.cfg_err}), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rl, cl, s, duty;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.cfg_row_len = '0;
    bus.cfg_col_len = '0;
    bus.cfg_stride  = '0;
    bus.pix_valid   = 1'b1;
    clear_counts();
    frame_total  = 0;
    exp_last_win = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", int'(bus.busy), 0);

    run_full(5, 5, 1, 100);
    run_full(5, 5, 2, 100);
    run_full(6, 4, 2, 50);
    run_full(3, 5, 2, 100);

    cfg_err_case(5, 5, 3);
    cfg_err_case(2, 5, 1);

    // Asynchronous reset in the middle of a frame.
    start_frame(5, 5, 1);
    drive(100, 12);
    bus.pix_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    exp_q.delete();
    run_full(5, 5, 1, 100);

    for (int i = 0; i < 6; i++) begin
      rl   = $urandom_range(3, 9);
      cl   = $urandom_range(3, 7);
      s    = $urandom_range(1, 2);
      duty = $urandom_range(30, 100);
      run_full(rl, cl, s, duty);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
